// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    // 65-bit IF/ID payload
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } if_id_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall holds everything, flush inserts a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   stall_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t ifid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_q <= '0;
        end else if (!stall_i) begin
            if (flush_i) begin
                ifid_q.valid <= 1'b0;
                ifid_q.instr <= '0;
            end else begin
                ifid_q.valid <= d_i.valid;
                // payload only moves with a real delivery
                if (d_i.valid) begin
                    ifid_q.instr   <= d_i.instr;
                    ifid_q.pcplus4 <= d_i.pcplus4;
                end
            end
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding request, kill on redirect, hold buffer during decode stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    input  logic [31:0] pcjumpD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic        fetch_busy
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  buf_q;
    logic         kill_q;

    logic         redirect;
    logic [31:0]  target;
    logic         deliver;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign redirect = (pcsrcD | jumpD) & validD & ~stallD;
    assign target   = jumpD ? pcjumpD : pcbranchD;

    // The word arriving alongside a redirect is the redirecting instruction's successor.
    always_comb begin
        deliver = 1'b0;
        if (!stallD && !redirect) begin
            deliver = (state_q == StHold) ||
                      ((state_q == StWait) && inst_data_ok && !kill_q);
        end
    end

    always_comb begin
        ifid_d         = '0;
        ifid_d.valid   = deliver;
        ifid_d.instr   = (state_q == StHold) ? buf_q : inst_rdata;
        ifid_d.pcplus4 = pc_plus4(pc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (redirect) pc_q <= target;
                    if (inst_addr_ok) begin
                        state_q <= StWait;
                        kill_q  <= redirect;
                    end
                end
                StWait: begin
                    if (inst_data_ok) begin
                        kill_q <= 1'b0;
                        if (redirect) begin
                            pc_q    <= target;
                            state_q <= StReq;
                        end else if (kill_q) begin
                            state_q <= StReq;
                        end else if (stallD) begin
                            buf_q   <= inst_rdata;
                            state_q <= StHold;
                        end else begin
                            pc_q    <= pc_plus4(pc_q);
                            state_q <= StReq;
                        end
                    end else if (redirect) begin
                        pc_q   <= target;
                        kill_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_q    <= target;
                        buf_q   <= '0;
                        state_q <= StReq;
                    end else if (!stallD) begin
                        pc_q    <= pc_plus4(pc_q);
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stallD),
        .flush_i (flushD),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign inst_req   = (state_q == StReq);
    assign inst_addr  = pc_q;
    assign pcF        = pc_q;
    assign instrD     = ifid_q.instr;
    assign pcplus4D   = ifid_q.pcplus4;
    assign validD     = ifid_q.valid;
    assign fetch_busy = ~deliver;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency, stall hold, redirects, flush, wrap, reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, flushD, pcsrcD, jumpD;
    logic [31:0] pcbranchD, pcjumpD;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD, fetch_busy;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallD       (stallD),
        .flushD       (flushD),
        .pcsrcD       (pcsrcD),
        .pcbranchD    (pcbranchD),
        .jumpD        (jumpD),
        .pcjumpD      (pcjumpD),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .pcF          (pcF),
        .instrD       (instrD),
        .pcplus4D     (pcplus4D),
        .validD       (validD),
        .fetch_busy   (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0;
        inst_addr_ok = 0; inst_data_ok = 0;
    endtask

    initial begin
        rst = 1; idle_inputs();
        pcbranchD = '0; pcjumpD = '0; inst_rdata = '0;
        #12;
        check_eq("rst_pcF", pcF, 32'hBFC0_0000);
        check_eq("rst_validD", 32'(validD), 0);
        check_eq("rst_instrD", instrD, 0);
        check_eq("rst_pcplus4D", pcplus4D, 0);
        check_eq("rst_inst_req", 32'(inst_req), 1);
        @(posedge clk); #1;
        rst = 0;

        // Best-case latency
        inst_addr_ok = 1; #1;
        check_eq("c1_inst_addr", inst_addr, 32'hBFC0_0000);
        check_eq("c1_busy", 32'(fetch_busy), 1);
        step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h2408_0001; #1;
        check_eq("c2_busy", 32'(fetch_busy), 0);
        step();
        inst_data_ok = 0; #1;
        check_eq("lat_instrD", instrD, 32'h2408_0001);
        check_eq("lat_pcplus4D", pcplus4D, 32'hBFC0_0004);
        check_eq("lat_validD", 32'(validD), 1);
        check_eq("lat_pcF", pcF, 32'hBFC0_0004);
        check_eq("lat_inst_req", 32'(inst_req), 1);

        // Data returns under a 3-cycle stall
        inst_addr_ok = 1; step();
        inst_addr_ok = 0;
        check_eq("pre_stall_validD", 32'(validD), 0);
        stallD = 1; inst_data_ok = 1; inst_rdata = 32'h1111_1111; step();
        inst_data_ok = 0; #1;
        check_eq("hold_state", 32'(dut.state_q), 32'(StHold));
        check_eq("hold_inst_req", 32'(inst_req), 0);
        check_eq("hold_validD", 32'(validD), 0);
        check_eq("hold_instrD", instrD, 32'h2408_0001);
        step(); step();
        check_eq("hold3_instrD", instrD, 32'h2408_0001);
        stallD = 0; #1;
        check_eq("unhold_busy", 32'(fetch_busy), 0);
        step();
        check_eq("unhold_instrD", instrD, 32'h1111_1111);
        check_eq("unhold_pcplus4D", pcplus4D, 32'hBFC0_0008);
        check_eq("unhold_validD", 32'(validD), 1);
        check_eq("unhold_pcF", pcF, 32'hBFC0_0008);
        inst_addr_ok = 1; step();
        inst_addr_ok = 0;
        check_eq("once_validD", 32'(validD), 0);
        check_eq("once_instrD", instrD, 32'h1111_1111);

        // Jump resolved while in WAIT kills the in-flight fetch
        inst_data_ok = 1; inst_rdata = 32'h0800_0040; step();
        inst_data_ok = 0;
        stallD = 1; inst_addr_ok = 1; step();
        stallD = 0; inst_addr_ok = 0;
        check_eq("jw_validD_held", 32'(validD), 1);
        jumpD = 1; pcjumpD = 32'hBFC0_0100; #1;
        check_eq("jw_busy", 32'(fetch_busy), 1);
        step();
        jumpD = 0;
        check_eq("jw_pcF", pcF, 32'hBFC0_0100);
        check_eq("jw_inst_req", 32'(inst_req), 0);
        inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF; #1;
        check_eq("jw_kill_busy", 32'(fetch_busy), 1);
        step();
        inst_data_ok = 0;
        check_eq("jw_inst_addr", inst_addr, 32'hBFC0_0100);
        check_eq("jw_inst_req2", 32'(inst_req), 1);
        check_eq("jw_validD", 32'(validD), 0);
        check_eq("jw_instrD", instrD, 32'h0800_0040);
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h0000_0042; step();
        inst_data_ok = 0;
        check_eq("jw_target_instrD", instrD, 32'h0000_0042);
        check_eq("jw_target_pcplus4D", pcplus4D, 32'hBFC0_0104);

        // Branch and jump together in REQ: jump target wins
        pcsrcD = 1; jumpD = 1; pcbranchD = 32'h8000_0000; pcjumpD = 32'hBFC0_0200;
        step();
        pcsrcD = 0; jumpD = 0;
        check_eq("bj_inst_addr", inst_addr, 32'hBFC0_0200);
        check_eq("bj_inst_req", 32'(inst_req), 1);
        check_eq("bj_validD", 32'(validD), 0);

        // Flush coinciding with delivery drops the word
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3333_3333; flushD = 1; #1;
        check_eq("fl_busy", 32'(fetch_busy), 0);
        step();
        inst_data_ok = 0; flushD = 0;
        check_eq("fl_validD", 32'(validD), 0);
        check_eq("fl_instrD", instrD, 0);
        check_eq("fl_pcF", pcF, 32'hBFC0_0204);

        // Branch in REQ with same-cycle addr_ok
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h4444_4444; step();
        inst_data_ok = 0;
        pcsrcD = 1; pcbranchD = 32'h0000_1000; inst_addr_ok = 1; step();
        pcsrcD = 0; inst_addr_ok = 0;
        check_eq("br_pcF", pcF, 32'h0000_1000);
        inst_data_ok = 1; inst_rdata = 32'h5555_5555; #1;
        check_eq("br_kill_busy", 32'(fetch_busy), 1);
        step();
        inst_data_ok = 0;
        check_eq("br_validD", 32'(validD), 0);
        check_eq("br_inst_addr", inst_addr, 32'h0000_1000);
        check_eq("br_instrD", instrD, 32'h4444_4444);

        // PC wrap at the top of the address space
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h6666_6666; step();
        inst_data_ok = 0;
        jumpD = 1; pcjumpD = 32'hFFFF_FFFC; step();
        jumpD = 0;
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h7777_7777; step();
        inst_data_ok = 0;
        check_eq("wrap_instrD", instrD, 32'h7777_7777);
        check_eq("wrap_pcplus4D", pcplus4D, 32'h0000_0000);
        check_eq("wrap_pcF", pcF, 32'h0000_0000);

        // Reset while WAIT, data_ok in the first post-reset cycle
        inst_addr_ok = 1; step();
        inst_addr_ok = 0; rst = 1; #1;
        check_eq("arst_pcF", pcF, 32'hBFC0_0000);
        check_eq("arst_validD", 32'(validD), 0);
        step();
        rst = 0; inst_data_ok = 1; inst_rdata = 32'h9999_9999; #1;
        check_eq("prst_busy", 32'(fetch_busy), 1);
        step();
        inst_data_ok = 0;
        check_eq("prst_validD", 32'(validD), 0);
        check_eq("prst_instrD", instrD, 0);
        check_eq("prst_pcF", pcF, 32'hBFC0_0000);
        check_eq("prst_inst_req", 32'(inst_req), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
